// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: sequences exception entry and exception return around the
// CSR register block. Fixed-priority exception capture, serialised CSR writes
// from the reservation station, and a pipeline stall/flush/redirect sequence.
module csr_trap_ctrl #(
    parameter int unsigned N_SRC        = 4,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     exc_valid,
    input  logic [N_SRC*32-1:0]  exc_pc,
    input  logic [N_SRC*5-1:0]   exc_cause,
    input  logic                 eret_valid,
    output logic                 eret_ready,
    input  logic [31:0]          epc_in,
    input  logic                 csr_wr_valid,
    output logic                 csr_wr_ready,
    input  logic [11:0]          csr_wr_addr,
    input  logic [31:0]          csr_wr_data,
    output logic                 CSR_done,
    output logic [11:0]          RS_CSR_Address,
    output logic [31:0]          CSR_Result,
    output logic                 exception_sig,
    output logic [31:0]          exception_pc,
    output logic [4:0]           exception_cause,
    output logic                 flush,
    output logic                 stall,
    output logic                 pc_redirect,
    output logic [31:0]          redirect_pc
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } state_e;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [31:0]  exc_pc_q, exc_pc_d;
    logic [4:0]   exc_cause_q, exc_cause_d;
    logic [31:0]  target_q, target_d;
    logic         csr_done_q, csr_done_d;
    logic [11:0]  csr_addr_q, csr_addr_d;
    logic [31:0]  csr_data_q, csr_data_d;

    logic         is_idle;
    logic         any_exc;
    logic [31:0]  grant_pc;
    logic [4:0]   grant_cause;

    assign is_idle = (state_q == IDLE);
    assign any_exc = |exc_valid;

    // A pending CSR write (possibly to EPC) blocks eret so epc_in is never stale.
    assign csr_wr_ready = is_idle & ~any_exc & ~eret_valid;
    assign eret_ready   = is_idle & ~any_exc & ~csr_done_q;

    // Fixed priority: scanning downward lets the lowest set index win.
    always_comb begin
        grant_pc    = '0;
        grant_cause = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (exc_valid[i]) begin
                grant_pc    = exc_pc[32*i +: 32];
                grant_cause = exc_cause[5*i +: 5];
            end
        end
    end

    // Trap sequencer next-state and latch updates.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        exc_pc_d    = exc_pc_q;
        exc_cause_d = exc_cause_q;
        target_d    = target_q;
        case (state_q)
            IDLE: begin
                if (any_exc) begin
                    exc_pc_d    = grant_pc;
                    exc_cause_d = grant_cause;
                    target_d    = TRAP_VECTOR;
                    state_d     = CAPTURE;
                end else if (eret_valid && eret_ready) begin
                    target_d = epc_in;
                    cnt_d    = '0;
                    state_d  = FLUSH;
                end
            end
            CAPTURE: begin
                cnt_d   = '0;
                state_d = FLUSH;
            end
            FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = REDIRECT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // CSR write port: one registered strobe per accepted RS request.
    always_comb begin
        csr_done_d = csr_wr_valid & csr_wr_ready;
        csr_addr_d = csr_done_d ? csr_wr_addr : csr_addr_q;
        csr_data_d = csr_done_d ? csr_wr_data : csr_data_q;
    end

    // State and data registers; reset abandons any sequence in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            exc_pc_q    <= '0;
            exc_cause_q <= '0;
            target_q    <= '0;
            csr_done_q  <= 1'b0;
            csr_addr_q  <= '0;
            csr_data_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exc_pc_q    <= exc_pc_d;
            exc_cause_q <= exc_cause_d;
            target_q    <= target_d;
            csr_done_q  <= csr_done_d;
            csr_addr_q  <= csr_addr_d;
            csr_data_q  <= csr_data_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    assign exception_sig   = (state_q == CAPTURE);
    assign flush           = (state_q == FLUSH);
    assign pc_redirect     = (state_q == REDIRECT);
    assign stall           = ~is_idle;
    assign exception_pc    = exc_pc_q;
    assign exception_cause = exc_cause_q;
    assign redirect_pc     = target_q;
    assign CSR_done        = csr_done_q;
    assign RS_CSR_Address  = csr_addr_q;
    assign CSR_Result      = csr_data_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Testbench for csr_trap_ctrl: directed scenarios plus a randomized run
// checked against a schedule-based reference model.
module tb_csr_trap_ctrl;

    localparam int          N  = 4;
    localparam int          F  = 2;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic          clk;
    logic          reset;
    logic [N-1:0]  exc_valid;
    logic [N*32-1:0] exc_pc;
    logic [N*5-1:0]  exc_cause;
    logic          eret_valid;
    logic          eret_ready;
    logic [31:0]   epc_in;
    logic          csr_wr_valid;
    logic          csr_wr_ready;
    logic [11:0]   csr_wr_addr;
    logic [31:0]   csr_wr_data;
    logic          CSR_done;
    logic [11:0]   RS_CSR_Address;
    logic [31:0]   CSR_Result;
    logic          exception_sig;
    logic [31:0]   exception_pc;
    logic [4:0]    exception_cause;
    logic          flush;
    logic          stall;
    logic          pc_redirect;
    logic [31:0]   redirect_pc;

    int n_cmp;
    int n_fail;

    csr_trap_ctrl #(.N_SRC(N), .TRAP_VECTOR(TV), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .reset(reset),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_cause(exc_cause),
        .eret_valid(eret_valid), .eret_ready(eret_ready), .epc_in(epc_in),
        .csr_wr_valid(csr_wr_valid), .csr_wr_ready(csr_wr_ready),
        .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
        .CSR_done(CSR_done), .RS_CSR_Address(RS_CSR_Address), .CSR_Result(CSR_Result),
        .exception_sig(exception_sig), .exception_pc(exception_pc),
        .exception_cause(exception_cause), .flush(flush), .stall(stall),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        exc_valid    = '0;
        exc_pc       = '0;
        exc_cause    = '0;
        eret_valid   = 1'b0;
        epc_in       = '0;
        csr_wr_valid = 1'b0;
        csr_wr_addr  = '0;
        csr_wr_data  = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        n_cmp++;
        if ({exception_sig, flush, stall, pc_redirect, CSR_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 00000", {exception_sig, flush, stall, pc_redirect, CSR_done});
        end
        n_cmp++;
        if ({exception_pc, exception_cause, redirect_pc, RS_CSR_Address, CSR_Result} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got pc=%h cause=%h rpc=%h addr=%h data=%h want all 0",
                     exception_pc, exception_cause, redirect_pc, RS_CSR_Address, CSR_Result);
        end
        n_cmp++;
        if ({csr_wr_ready, eret_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 11", {csr_wr_ready, eret_ready});
        end
    endtask

    task automatic test_single_exception;
        int stall_n, flush_n, sig_n, redir_at;
        logic [31:0] rpc;
        idle_inputs();
        exc_pc[64 +: 32]   = 32'h0000_0040;
        exc_cause[10 +: 5] = 5'd3;
        exc_valid          = 4'b0100;
        #1;
        n_cmp++;
        if (csr_wr_ready !== 1'b0) begin
            n_fail++; $display("FAIL single_csr_ready: got %b want 0", csr_wr_ready);
        end
        tick();
        exc_valid = '0;
        n_cmp++;
        if ({exception_sig, exception_pc, exception_cause} !== {1'b1, 32'h40, 5'd3}) begin
            n_fail++;
            $display("FAIL single_capture: got sig=%b pc=%h cause=%0d want sig=1 pc=40 cause=3",
                     exception_sig, exception_pc, exception_cause);
        end
        stall_n = 0; flush_n = 0; sig_n = 0; redir_at = -1; rpc = '0;
        for (int c = 0; c < 6; c++) begin
            if (stall) stall_n++;
            if (flush) flush_n++;
            if (exception_sig) sig_n++;
            if (pc_redirect && redir_at < 0) begin redir_at = c; rpc = redirect_pc; end
            tick();
        end
        n_cmp++;
        if (stall_n !== 4 || flush_n !== F || sig_n !== 1) begin
            n_fail++;
            $display("FAIL single_counts: got stall=%0d flush=%0d sig=%0d want 4 %0d 1", stall_n, flush_n, sig_n, F);
        end
        n_cmp++;
        if (redir_at !== F + 1 || rpc !== TV) begin
            n_fail++;
            $display("FAIL single_redirect: got at=%0d pc=%h want at=%0d pc=%h", redir_at, rpc, F + 1, TV);
        end
    endtask

    task automatic test_priority;
        int sig_n;
        idle_inputs();
        exc_pc[32 +: 32]   = 32'h10;
        exc_pc[96 +: 32]   = 32'h30;
        exc_cause[5 +: 5]  = 5'd1;
        exc_cause[15 +: 5] = 5'd3;
        exc_valid          = 4'b1010;
        tick();
        n_cmp++;
        if ({exception_pc, exception_cause} !== {32'h10, 5'd1}) begin
            n_fail++;
            $display("FAIL prio_capture: got pc=%h cause=%0d want pc=10 cause=1", exception_pc, exception_cause);
        end
        sig_n = 0;
        for (int c = 0; c < 4; c++) begin
            if (exception_sig) sig_n++;
            if (c == 3) exc_valid = '0;
            tick();
        end
        n_cmp++;
        if (sig_n !== 1) begin
            n_fail++; $display("FAIL prio_single_capture: got %0d strobes want 1", sig_n);
        end
        n_cmp++;
        if ({stall, exception_pc} !== {1'b0, 32'h10}) begin
            n_fail++;
            $display("FAIL prio_hold: got stall=%b pc=%h want stall=0 pc=10", stall, exception_pc);
        end
    endtask

    task automatic test_eret;
        int flush_n, redir_at;
        logic [31:0] rpc;
        idle_inputs();
        epc_in     = 32'h0000_0044;
        eret_valid = 1'b1;
        #1;
        n_cmp++;
        if ({eret_ready, csr_wr_ready} !== 2'b10) begin
            n_fail++; $display("FAIL eret_ready: got %b want 10", {eret_ready, csr_wr_ready});
        end
        tick();
        eret_valid = 1'b0;
        flush_n = 0; redir_at = -1; rpc = '0;
        for (int c = 0; c < 5; c++) begin
            if (flush) flush_n++;
            if (pc_redirect && redir_at < 0) begin redir_at = c; rpc = redirect_pc; end
            tick();
        end
        n_cmp++;
        if (flush_n !== F || redir_at !== F || rpc !== 32'h44) begin
            n_fail++;
            $display("FAIL eret_seq: got flush=%0d at=%0d pc=%h want %0d %0d 44", flush_n, redir_at, rpc, F, F);
        end
    endtask

    task automatic test_csr_write;
        int waited;
        bit accepted;
        idle_inputs();
        csr_wr_valid = 1'b1;
        csr_wr_addr  = 12'h000;
        csr_wr_data  = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (csr_wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL csr_ready_idle: got %b want 1", csr_wr_ready);
        end
        tick();
        csr_wr_valid = 1'b0;
        n_cmp++;
        if ({CSR_done, RS_CSR_Address, CSR_Result} !== {1'b1, 12'h000, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL csr_write: got done=%b addr=%h data=%h want 1 000 deadbeef", CSR_done, RS_CSR_Address, CSR_Result);
        end
        tick();
        n_cmp++;
        if (CSR_done !== 1'b0) begin
            n_fail++; $display("FAIL csr_done_pulse: got %b want 0", CSR_done);
        end
        // Same kind of request issued while the pipeline is flushing.
        exc_pc[0 +: 32]   = 32'h200;
        exc_cause[0 +: 5] = 5'd2;
        exc_valid         = 4'b0001;
        tick();
        exc_valid = '0;
        tick();
        csr_wr_valid = 1'b1;
        csr_wr_addr  = 12'h341;
        csr_wr_data  = 32'h1234_5678;
        waited = 0; accepted = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (csr_wr_ready) begin accepted = 1; break; end
            n_cmp++;
            if (CSR_done !== 1'b0) begin
                n_fail++; $display("FAIL csr_early_done: got %b want 0", CSR_done);
            end
            tick();
            waited++;
        end
        n_cmp++;
        if (!accepted || waited !== F + 1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL csr_wait: got accepted=%0d waited=%0d stall=%b want 1 %0d 0", accepted, waited, stall, F + 1);
        end
        tick();
        csr_wr_valid = 1'b0;
        n_cmp++;
        if ({CSR_done, RS_CSR_Address, CSR_Result} !== {1'b1, 12'h341, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL csr_after_flush: got done=%b addr=%h data=%h want 1 341 12345678", CSR_done, RS_CSR_Address, CSR_Result);
        end
        tick();
    endtask

    task automatic test_eret_after_write;
        idle_inputs();
        csr_wr_valid = 1'b1;
        csr_wr_addr  = 12'h341;
        csr_wr_data  = 32'hAAAA_0000;
        epc_in       = 32'hAAAA_0000;
        tick();
        csr_wr_valid = 1'b0;
        eret_valid   = 1'b1;
        #1;
        n_cmp++;
        if ({CSR_done, eret_ready} !== 2'b10) begin
            n_fail++; $display("FAIL hazard_block: got done/ready=%b want 10", {CSR_done, eret_ready});
        end
        tick();
        #1;
        n_cmp++;
        if (eret_ready !== 1'b1) begin
            n_fail++; $display("FAIL hazard_release: got %b want 1", eret_ready);
        end
        tick();
        eret_valid = 1'b0;
        n_cmp++;
        if (flush !== 1'b1) begin
            n_fail++; $display("FAIL hazard_flush: got %b want 1", flush);
        end
        tick();
        tick();
        n_cmp++;
        if ({pc_redirect, redirect_pc} !== {1'b1, 32'hAAAA_0000}) begin
            n_fail++; $display("FAIL hazard_redirect: got %b pc=%h want 1 aaaa0000", pc_redirect, redirect_pc);
        end
        tick();
    endtask

    task automatic test_collision;
        idle_inputs();
        exc_pc[0 +: 32]   = 32'h80;
        exc_cause[0 +: 5] = 5'd7;
        exc_valid         = 4'b0001;
        eret_valid        = 1'b1;
        epc_in            = 32'h44;
        csr_wr_valid      = 1'b1;
        csr_wr_addr       = 12'h005;
        csr_wr_data       = 32'h1;
        #1;
        n_cmp++;
        if ({csr_wr_ready, eret_ready} !== 2'b00) begin
            n_fail++; $display("FAIL collide_ready: got %b want 00", {csr_wr_ready, eret_ready});
        end
        tick();
        idle_inputs();
        n_cmp++;
        if ({exception_sig, exception_pc, exception_cause, CSR_done} !== {1'b1, 32'h80, 5'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL collide_capture: got sig=%b pc=%h cause=%0d done=%b want 1 80 7 0",
                     exception_sig, exception_pc, exception_cause, CSR_done);
        end
        repeat (F + 1) tick();
        n_cmp++;
        if ({pc_redirect, redirect_pc} !== {1'b1, TV}) begin
            n_fail++; $display("FAIL collide_redirect: got %b pc=%h want 1 %h", pc_redirect, redirect_pc, TV);
        end
        tick();
    endtask

    task automatic test_async_reset;
        int bad_n;
        idle_inputs();
        epc_in     = 32'h44;
        eret_valid = 1'b1;
        tick();
        eret_valid = 1'b0;
        n_cmp++;
        if (flush !== 1'b1) begin
            n_fail++; $display("FAIL areset_setup: got flush=%b want 1", flush);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({flush, stall, pc_redirect, exception_sig} !== 4'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: got %b want 0000", {flush, stall, pc_redirect, exception_sig});
        end
        @(negedge clk);
        reset = 1'b1;
        bad_n = 0;
        for (int c = 0; c < 6; c++) begin
            if (pc_redirect || stall) bad_n++;
            tick();
        end
        n_cmp++;
        if (bad_n !== 0 || exception_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_after: got %0d busy cycles pc=%h want 0 0", bad_n, exception_pc);
        end
    endtask

    // Reference model: an accepted trap becomes a list of per-cycle output
    // expectations; the block is busy exactly while that list is non-empty.
    typedef struct packed {
        logic        sig;
        logic        fl;
        logic        rd;
        logic [31:0] rpc;
    } ev_t;

    task automatic test_random;
        ev_t         sched[$];
        ev_t         cur;
        logic [31:0] m_pc, m_data;
        logic [4:0]  m_cause;
        logic [11:0] m_addr;
        logic        m_done, busy, exp_cr, exp_er, acc;
        int          g;
        do_reset();
        m_pc = '0; m_cause = '0; m_addr = '0; m_data = '0; m_done = 0; acc = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (acc) csr_wr_valid = 1'b0;
            exc_valid  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            exc_pc     = {$urandom, $urandom, $urandom, $urandom};
            exc_cause  = 20'($urandom);
            eret_valid = ($urandom_range(0, 5) == 0);
            epc_in     = $urandom;
            if (!csr_wr_valid && $urandom_range(0, 2) == 0) begin
                csr_wr_valid = 1'b1;
                csr_wr_addr  = 12'($urandom);
                csr_wr_data  = $urandom;
            end
            #1;
            busy   = (sched.size() != 0);
            cur    = busy ? sched[0] : '0;
            exp_cr = !busy && exc_valid == '0 && !eret_valid;
            exp_er = !busy && exc_valid == '0 && !m_done;
            n_cmp++;
            if ({exception_sig, flush, stall, pc_redirect, CSR_done, csr_wr_ready, eret_ready} !==
                {cur.sig, cur.fl, busy, cur.rd, m_done, exp_cr, exp_er}) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc %0d: got %b want %b", cyc,
                         {exception_sig, flush, stall, pc_redirect, CSR_done, csr_wr_ready, eret_ready},
                         {cur.sig, cur.fl, busy, cur.rd, m_done, exp_cr, exp_er});
            end
            n_cmp++;
            if ({exception_pc, exception_cause} !== {m_pc, m_cause}) begin
                n_fail++;
                $display("FAIL rand_capture cyc %0d: got %h/%0d want %h/%0d", cyc, exception_pc, exception_cause, m_pc, m_cause);
            end
            if (m_done) begin
                n_cmp++;
                if ({RS_CSR_Address, CSR_Result} !== {m_addr, m_data}) begin
                    n_fail++;
                    $display("FAIL rand_csr cyc %0d: got %h/%h want %h/%h", cyc, RS_CSR_Address, CSR_Result, m_addr, m_data);
                end
            end
            if (cur.rd) begin
                n_cmp++;
                if (redirect_pc !== cur.rpc) begin
                    n_fail++;
                    $display("FAIL rand_redirect cyc %0d: got %h want %h", cyc, redirect_pc, cur.rpc);
                end
            end
            acc = csr_wr_valid && exp_cr;
            if (acc) begin m_addr = csr_wr_addr; m_data = csr_wr_data; end
            m_done = acc;
            if (busy) begin
                void'(sched.pop_front());
            end else if (exc_valid != '0) begin
                g = 0;
                for (int i = N - 1; i >= 0; i--) if (exc_valid[i]) g = i;
                m_pc    = exc_pc[32*g +: 32];
                m_cause = exc_cause[5*g +: 5];
                sched.push_back('{sig: 1'b1, fl: 1'b0, rd: 1'b0, rpc: 32'h0});
                for (int k = 0; k < F; k++) sched.push_back('{sig: 1'b0, fl: 1'b1, rd: 1'b0, rpc: 32'h0});
                sched.push_back('{sig: 1'b0, fl: 1'b0, rd: 1'b1, rpc: TV});
            end else if (eret_valid && exp_er) begin
                for (int k = 0; k < F; k++) sched.push_back('{sig: 1'b0, fl: 1'b1, rd: 1'b0, rpc: 32'h0});
                sched.push_back('{sig: 1'b0, fl: 1'b0, rd: 1'b1, rpc: epc_in});
            end
            tick();
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        idle_inputs();
        test_reset();
        test_single_exception();
        test_priority();
        test_eret();
        test_csr_write();
        test_eret_after_write();
        test_collision();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
